add4_resp_checker: RTL

ADD4_RESP_CHECKER -- requirements
Module: add4_resp_checker

---
 rtl/add4_resp_checker.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/add4_resp_checker.sv
// Exhaustive self-test sequencer for a 4-bit adder: sweeps all 512 {Cin,B,A}
// vectors and checks each {Cout,S} response against the true 5-bit sum.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands held at 0
// RUN   | driving vector v = 0..511, one per cycle
// DRAIN | LAT cycles waiting for the last responses (skipped when LAT=0)
// DONE  | sweep finished; pass reflects err_cnt, held until next start
module add4_resp_checker #(
    parameter int LAT = 1
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       Cin,
    input  logic [3:0] S,
    input  logic       Cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_cnt,
    output logic [8:0] first_idx,
    output logic [4:0] first_got
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int             D          = (LAT > 0) ? LAT : 1;
    localparam logic [1:0]     DRAIN_LOAD = 2'(D - 1);
    localparam logic [9:0]     ERR_MAX    = 10'h3FF;

    state_t     state;
    state_t     state_nxt;
    logic [8:0] vec;
    logic [1:0] drain_cnt;

    logic       sweep_go;
    logic       active;
    logic       flush;
    logic       last_vec;

    logic       in_valid;
    logic [4:0] in_exp;
    logic       cmp_valid;
    logic [4:0] cmp_exp;
    logic [8:0] cmp_idx;
    logic [4:0] got;
    logic       mismatch;

    assign sweep_go = start && ((state == IDLE) || (state == DONE));
    assign active   = (state == RUN) || (state == DRAIN);
    assign flush    = abort && active;
    assign last_vec = (vec == 9'd511);

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_vec) begin
                    state_nxt = (LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (drain_cnt == 2'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        A    = 4'd0;
        B    = 4'd0;
        Cin  = 1'b0;
        busy = active;
        done = (state == DONE);
        pass = (state == DONE) && (err_cnt == 10'd0);
        if (state == RUN) begin
            A   = vec[3:0];
            B   = vec[7:4];
            Cin = vec[8];
        end
    end

    // ---------------- vector index and drain timer ----------------
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            vec <= 9'd0;
        end else if (sweep_go || flush) begin
            vec <= 9'd0;
        end else if (state == RUN) begin
            vec <= vec + 9'd1;
        end
    end

    // Down-counter loaded on the last RUN cycle; DRAIN ends at terminal count.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            drain_cnt <= 2'd0;
        end else if ((state == RUN) && last_vec) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == DRAIN) && (drain_cnt != 2'd0)) begin
            drain_cnt <= drain_cnt - 2'd1;
        end
    end

    // ---------------- expected-response pipeline ----------------
    assign in_valid = (state == RUN);
    assign in_exp   = {1'b0, A} + {1'b0, B} + {4'd0, Cin};

    generate
        if (LAT == 0) begin : g_comb
            assign cmp_valid = in_valid;
            assign cmp_exp   = in_exp;
            assign cmp_idx   = vec;
        end else begin : g_pipe
            logic [LAT-1:0] vld_q;
            logic [4:0]     exp_q [LAT];
            logic [8:0]     idx_q [LAT];

            always_ff @(posedge CLK) begin
                if (!RST_n || flush) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= in_valid;
                    for (int i = 1; i < LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            // Payload only matters when its valid bit is set, so no reset.
            always_ff @(posedge CLK) begin
                exp_q[0] <= in_exp;
                idx_q[0] <= vec;
                for (int i = 1; i < LAT; i++) begin
                    exp_q[i] <= exp_q[i-1];
                    idx_q[i] <= idx_q[i-1];
                end
            end

            assign cmp_valid = vld_q[LAT-1];
            assign cmp_exp   = exp_q[LAT-1];
            assign cmp_idx   = idx_q[LAT-1];
        end
    endgenerate

    // ---------------- compare and error capture ----------------
    assign got      = {Cout, S};
    assign mismatch = cmp_valid && (got != cmp_exp);

    // err_cnt==0 doubles as the "no mismatch seen yet" flag for the capture.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            err_cnt   <= 10'd0;
            first_idx <= 9'd0;
            first_got <= 5'd0;
        end else if (sweep_go) begin
            err_cnt   <= 10'd0;
            first_idx <= 9'd0;
            first_got <= 5'd0;
        end else if (mismatch) begin
            if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + 10'd1;
            end
            if (err_cnt == 10'd0) begin
                first_idx <= cmp_idx;
                first_got <= got;
            end
        end
    end

endmodule
